lab5_mem_arbiter: RTL and testbench

//  Two-port front end for the 256x32 banked Lab5 memory (4 banks x 64 words, bank = addr[7:6]).

---
 rtl/lab5_mem_arbiter_pkg.sv | 26 ++
 rtl/lab5_mem_arbiter_if.sv | 46 ++++
 rtl/lab5_rr_arbiter2.sv | 24 ++
 rtl/lab5_mem_arbiter.sv | 129 ++++++++++++
 tb/tb_lab5_mem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lab5_mem_arbiter_pkg.sv
// Shared types and constants for the Lab5 banked-memory front end.
//   state_t    : arbiter FSM states
//   ADDR_W_DEF : default word address width (bank = addr[BANK_HI:BANK_LO])
//   DATA_W_DEF : default data width
//   is_prot_bank() : true for the write-protected bank (used only with LAB5_MEM_ARB_WPROT_EN)
package lab5_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned BANK_HI    = 7;
  localparam int unsigned BANK_LO    = 6;
  localparam logic [1:0]  PROT_BANK  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Bank-select bits compared against the protected bank.
  function automatic logic is_prot_bank(input logic [1:0] bank);
    return bank == PROT_BANK;
  endfunction

endpackage

// File: rtl/lab5_mem_arbiter_if.sv
// Bus bundle between the two CPU-side requesters, the arbiter and the memory.
//   reqN_* : request handshake and payload (N = 0, 1)
//   rspN_* : completion pulse, read data and error flag
//   mem_*  : single-master memory port
// Modports: slave = arbiter view, master = requester/memory environment view.
interface lab5_mem_arbiter_if #(
  parameter int unsigned ADDR_W = lab5_mem_pkg::ADDR_W_DEF,
  parameter int unsigned DATA_W = lab5_mem_pkg::DATA_W_DEF
);

  logic              req0_valid, req1_valid;
  logic              req0_ready, req1_ready;
  logic              req0_write, req1_write;
  logic [ADDR_W-1:0] req0_addr,  req1_addr;
  logic [DATA_W-1:0] req0_wdata, req1_wdata;

  logic              rsp0_valid, rsp1_valid;
  logic [DATA_W-1:0] rsp0_rdata, rsp1_rdata;
  logic              rsp0_err,   rsp1_err;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_write;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_dout;

  modport slave (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_rdata, rsp0_err,
    output rsp1_valid, rsp1_rdata, rsp1_err,
    output mem_addr, mem_write, mem_wdata,
    input  mem_dout
  );

  modport master (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_rdata, rsp0_err,
    input  rsp1_valid, rsp1_rdata, rsp1_err,
    input  mem_addr, mem_write, mem_wdata,
    output mem_dout
  );

endinterface

// File: rtl/lab5_rr_arbiter2.sv
// Combinational two-way round-robin pick.
//   req[1:0] : request vector
//   last     : ID granted most recently; on a tie the other one wins
//   gnt[1:0] : one-hot grant (0 when no request)
//   gnt_id   : index of the granted requester
module lab5_rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    gnt_id = gnt[1];
  end

endmodule

// File: rtl/lab5_mem_arbiter.sv
// Two-port round-robin front end for the 256x32 banked Lab5 memory.
// One transaction at a time: IDLE (grant) -> ACCESS -> [WAIT x RD_LAT] -> RESP.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   bus      : lab5_mem_arbiter_if.slave (request/response handshakes, memory port)
// Optional build macro LAB5_MEM_ARB_WPROT_EN: writes to bank 3 are suppressed at the
// memory and answered with err=1; without it err is always 0.
module lab5_mem_arbiter
  import lab5_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = lab5_mem_pkg::ADDR_W_DEF,
  parameter int unsigned DATA_W = lab5_mem_pkg::DATA_W_DEF,
  parameter int unsigned RD_LAT = 1
) (
  input logic                clk,
  input logic                rst,
  lab5_mem_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t            state_q, state_d;
  logic              last_q;
  logic              gid_q;
  logic              wr_q;
  logic              prot_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [1:0]        gnt;
  logic              gnt_id;
  logic              grant_en;
  logic              wait_last;

  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_prot;

  lab5_rr_arbiter2 u_rr (
    .req    ({bus.req1_valid, bus.req0_valid}),
    .last   (last_q),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  // Payload of the requester being granted this cycle.
  assign sel_write = gnt_id ? bus.req1_write : bus.req0_write;
  assign sel_addr  = gnt_id ? bus.req1_addr  : bus.req0_addr;
  assign sel_wdata = gnt_id ? bus.req1_wdata : bus.req0_wdata;

`ifdef LAB5_MEM_ARB_WPROT_EN
  assign sel_prot = sel_write & is_prot_bank(sel_addr[BANK_HI:BANK_LO]);
`else
  assign sel_prot = 1'b0;
`endif

  assign wait_last = (cnt_q == CNT_W'(RD_LAT - 1));

  // Next-state logic; grant_en is the single point where a request is accepted.
  always_comb begin
    state_d  = state_q;
    grant_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|gnt) begin
          grant_en = 1'b1;
          state_d  = ACCESS;
        end
      end
      ACCESS:  state_d = wr_q ? RESP : WAIT;
      WAIT:    if (wait_last) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Transaction latches, round-robin history, WAIT counter and read capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q  <= 1'b1;
      gid_q   <= 1'b0;
      wr_q    <= 1'b0;
      prot_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      if (grant_en) begin
        gid_q   <= gnt_id;
        last_q  <= gnt_id;
        wr_q    <= sel_write;
        prot_q  <= sel_prot;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        // Writes respond with rdata=0.
        rdata_q <= '0;
      end
      if (state_q == ACCESS) cnt_q <= '0;
      else if (state_q == WAIT) cnt_q <= cnt_q + CNT_W'(1);
      if (state_q == WAIT && wait_last) rdata_q <= bus.mem_dout;
    end
  end

  assign bus.req0_ready = grant_en & gnt[0];
  assign bus.req1_ready = grant_en & gnt[1];

  // Address/data registers hold between transactions; write strobe only in ACCESS.
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_write = (state_q == ACCESS) & wr_q & ~prot_q;

  assign bus.rsp0_valid = (state_q == RESP) & ~gid_q;
  assign bus.rsp1_valid = (state_q == RESP) &  gid_q;
  assign bus.rsp0_rdata = bus.rsp0_valid ? rdata_q : '0;
  assign bus.rsp1_rdata = bus.rsp1_valid ? rdata_q : '0;
  assign bus.rsp0_err   = bus.rsp0_valid & prot_q;
  assign bus.rsp1_err   = bus.rsp1_valid & prot_q;

endmodule

// File: tb/tb_lab5_mem_arbiter.sv
// Self-checking bench for lab5_mem_arbiter: directed scenarios plus random traffic,
// checked every cycle against a transaction-timeline model with a shadow memory.
module tb_lab5_mem_arbiter;
  import lab5_mem_pkg::*;

  localparam int unsigned AW     = 8;
  localparam int unsigned DW     = 32;
  localparam int unsigned RD_LAT = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lab5_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  lab5_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural RAM with a one-clock registered read.
  logic [DW-1:0] ram [256] = '{default: '0};
  always @(posedge clk) begin
    if (bus.mem_write) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_dout <= ram[bus.mem_addr];
  end

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  typedef struct {
    int   port;
    int   cyc;
  } gnt_rec_t;

  typedef struct {
    int            port;
    int            cyc;
    logic [DW-1:0] data;
    logic          err;
  } rsp_rec_t;

  req_t     q0[$], q1[$];
  gnt_rec_t glog[$];
  rsp_rec_t rlog[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic rdy0_seen = 1'b0, rdy1_seen = 1'b0;

  // Reference model: one outstanding transaction described by its timeline.
  logic [DW-1:0] shadow [256];
  logic          m_busy = 1'b0;
  int            m_last = 1;
  int            m_id, m_acc, m_rsp;
  logic          m_wr, m_prot;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_d, m_rd;
  logic [AW-1:0] m_addr_out  = '0;
  logic [DW-1:0] m_wdata_out = '0;

  function automatic logic prot_of(input logic wr, input logic [AW-1:0] a);
`ifdef LAB5_MEM_ARB_WPROT_EN
    return wr && (a[7:6] == 2'b11);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison and model update, sampled at the falling edge.
  task automatic compare();
    int   g;
    logic acc_now, rsp_now;
    logic exp_v0, exp_v1;
    cyc++;
    rdy0_seen = bus.req0_ready;
    rdy1_seen = bus.req1_ready;
    if (bus.req0_ready) glog.push_back('{0, cyc});
    if (bus.req1_ready) glog.push_back('{1, cyc});
    if (bus.rsp0_valid) rlog.push_back('{0, cyc, bus.rsp0_rdata, bus.rsp0_err});
    if (bus.rsp1_valid) rlog.push_back('{1, cyc, bus.rsp1_rdata, bus.rsp1_err});

    if (rst) begin
      chk("rst_ready0", 64'(bus.req0_ready), 0);
      chk("rst_ready1", 64'(bus.req1_ready), 0);
      chk("rst_rsp0",   64'({bus.rsp0_valid, bus.rsp0_err, bus.rsp0_rdata}), 0);
      chk("rst_rsp1",   64'({bus.rsp1_valid, bus.rsp1_err, bus.rsp1_rdata}), 0);
      chk("rst_mem",    64'({bus.mem_write, bus.mem_addr}), 0);
      chk("rst_wdata",  64'(bus.mem_wdata), 0);
      m_busy = 1'b0;
      m_last = 1;
      m_addr_out  = '0;
      m_wdata_out = '0;
      return;
    end

    g = -1;
    if (!m_busy) begin
      if (bus.req0_valid && bus.req1_valid) g = (m_last == 1) ? 0 : 1;
      else if (bus.req0_valid) g = 0;
      else if (bus.req1_valid) g = 1;
    end
    chk("ready0", 64'(bus.req0_ready), 64'(g == 0));
    chk("ready1", 64'(bus.req1_ready), 64'(g == 1));

    acc_now = m_busy && (cyc == m_acc);
    if (acc_now) begin
      m_addr_out  = m_a;
      m_wdata_out = m_d;
    end
    chk("mem_write", 64'(bus.mem_write), 64'(acc_now && m_wr && !m_prot));
    chk("mem_addr",  64'(bus.mem_addr),  64'(m_addr_out));
    chk("mem_wdata", 64'(bus.mem_wdata), 64'(m_wdata_out));

    rsp_now = m_busy && (cyc == m_rsp);
    exp_v0  = rsp_now && (m_id == 0);
    exp_v1  = rsp_now && (m_id == 1);
    chk("rsp0_valid", 64'(bus.rsp0_valid), 64'(exp_v0));
    chk("rsp1_valid", 64'(bus.rsp1_valid), 64'(exp_v1));
    chk("rsp0_rdata", 64'(bus.rsp0_rdata), exp_v0 ? 64'(m_rd) : 64'd0);
    chk("rsp1_rdata", 64'(bus.rsp1_rdata), exp_v1 ? 64'(m_rd) : 64'd0);
    chk("rsp0_err",   64'(bus.rsp0_err),   64'(exp_v0 && m_prot));
    chk("rsp1_err",   64'(bus.rsp1_err),   64'(exp_v1 && m_prot));
    if (rsp_now) m_busy = 1'b0;

    if (g >= 0) begin
      m_busy = 1'b1;
      m_id   = g;
      m_wr   = (g == 0) ? bus.req0_write : bus.req1_write;
      m_a    = (g == 0) ? bus.req0_addr  : bus.req1_addr;
      m_d    = (g == 0) ? bus.req0_wdata : bus.req1_wdata;
      m_prot = prot_of(m_wr, m_a);
      m_acc  = cyc + 1;
      m_rsp  = m_wr ? cyc + 2 : cyc + 2 + int'(RD_LAT);
      m_rd   = m_wr ? '0 : shadow[m_a];
      if (m_wr && !m_prot) shadow[m_a] = m_d;
      m_last = g;
    end
  endtask

  // Requesters hold valid/payload until the falling-edge sample saw ready.
  task automatic drive();
    if (rdy0_seen && q0.size() > 0) void'(q0.pop_front());
    if (rdy1_seen && q1.size() > 0) void'(q1.pop_front());
    bus.req0_valid = (q0.size() > 0);
    bus.req0_write = (q0.size() > 0) ? q0[0].wr   : 1'b0;
    bus.req0_addr  = (q0.size() > 0) ? q0[0].addr : '0;
    bus.req0_wdata = (q0.size() > 0) ? q0[0].data : '0;
    bus.req1_valid = (q1.size() > 0);
    bus.req1_write = (q1.size() > 0) ? q1[0].wr   : 1'b0;
    bus.req1_addr  = (q1.size() > 0) ? q1[0].addr : '0;
    bus.req1_wdata = (q1.size() > 0) ? q1[0].data : '0;
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || m_busy) && n < budget) begin
      tick();
      n++;
    end
    tests++;
    if (n >= budget) begin
      fails++;
      $display("FAIL drain_timeout cyc=%0d actual=%0d cycles required<%0d", cyc, n, budget);
    end
  endtask

  initial begin
    int gs, rs;
    int n;
    for (int i = 0; i < 256; i++) shadow[i] = '0;
    drive();

    // Reset state.
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // 1: single write.
    gs = glog.size(); rs = rlog.size();
    q0.push_back('{1'b1, 8'h05, 32'hDEADBEEF});
    drain(20);
    chk("t1_ngrant", 64'(glog.size() - gs), 1);
    chk("t1_port",   64'(glog[gs].port), 0);
    chk("t1_rport",  64'(rlog[rs].port), 0);
    chk("t1_lat",    64'(rlog[rs].cyc - glog[gs].cyc), 2);
    chk("t1_err",    64'(rlog[rs].err), 0);

    // 2: read back.
    gs = glog.size(); rs = rlog.size();
    q0.push_back('{1'b0, 8'h05, 32'h0});
    drain(20);
    chk("t2_nrsp",  64'(rlog.size() - rs), 1);
    chk("t2_rport", 64'(rlog[rs].port), 0);
    chk("t2_data",  64'(rlog[rs].data), 64'h DEADBEEF);
    chk("t2_lat",   64'(rlog[rs].cyc - glog[gs].cyc), 3);

    // 3: preload, then continuous contention (last grant is req1, so req0 wins first).
    q0.push_back('{1'b1, 8'h10, 32'h11110010});
    drain(20);
    q1.push_back('{1'b1, 8'h50, 32'h55550050});
    drain(20);
    gs = glog.size(); rs = rlog.size();
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{1'b0, 8'h10, 32'h0});
      q1.push_back('{1'b0, 8'h50, 32'h0});
    end
    drain(80);
    chk("t3_ngrant", 64'(glog.size() - gs), 8);
    for (int i = 0; i < 8; i++) begin
      chk("t3_order", 64'(glog[gs+i].port), 64'(i % 2));
      chk("t3_data",  64'(rlog[rs+i].data), (i % 2 == 0) ? 64'h11110010 : 64'h55550050);
      if (i < 7) chk("t3_rsp_before_next", 64'(rlog[rs+i].cyc < glog[gs+i+1].cyc), 1);
    end

    // 4: bank boundary, no aliasing.
    rs = rlog.size();
    q0.push_back('{1'b1, 8'h3F, 32'hA5A5003F});
    q0.push_back('{1'b0, 8'h3F, 32'h0});
    q1.push_back('{1'b1, 8'h40, 32'h5A5A0040});
    q1.push_back('{1'b0, 8'h40, 32'h0});
    drain(60);
    chk("t4_nrsp", 64'(rlog.size() - rs), 4);
    chk("t4_rd3f", 64'(rlog[rs+2].data), 64'hA5A5003F);
    chk("t4_rd40", 64'(rlog[rs+3].data), 64'h5A5A0040);

    // 5: reset during WAIT of a read.
    gs = glog.size(); rs = rlog.size();
    q0.push_back('{1'b0, 8'h3F, 32'h0});
    n = 0;
    while (glog.size() == gs && n < 20) begin tick(); n++; end
    chk("t5_granted", 64'(glog.size() - gs), 1);
    tick();               // now 1 ns into the WAIT cycle
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("t5_no_rsp", 64'(rlog.size() - rs), 0);
    gs = glog.size();
    q0.push_back('{1'b0, 8'h40, 32'h0});
    q1.push_back('{1'b0, 8'h3F, 32'h0});
    drain(40);
    chk("t5_tie_req0", 64'(glog[gs].port), 0);
    chk("t5_rd40",     64'(rlog[rs].data), 64'h5A5A0040);

    // 6: write to the protected bank.
    q0.push_back('{1'b1, 8'hC0, 32'hCAFE00C0});
    drain(20);
    gs = glog.size(); rs = rlog.size();
    q0.push_back('{1'b1, 8'hC0, 32'h12345678});
    drain(20);
`ifdef LAB5_MEM_ARB_WPROT_EN
    chk("t6_werr", 64'(rlog[rs].err), 1);
`else
    chk("t6_werr", 64'(rlog[rs].err), 0);
`endif
    chk("t6_wlat", 64'(rlog[rs].cyc - glog[gs].cyc), 2);
    rs = rlog.size();
    q0.push_back('{1'b0, 8'hC0, 32'h0});
    drain(20);
`ifdef LAB5_MEM_ARB_WPROT_EN
    chk("t6_rdata", 64'(rlog[rs].data), 64'hCAFE00C0);
`else
    chk("t6_rdata", 64'(rlog[rs].data), 64'h12345678);
`endif
    chk("t6_rerr", 64'(rlog[rs].err), 0);

    // Random mixed traffic across all banks.
    for (int i = 0; i < 40; i++) begin
      q0.push_back('{1'($urandom), {2'($urandom), 3'b000, 3'($urandom)}, 32'($urandom)});
      if (i < 25) q1.push_back('{1'($urandom), {2'($urandom), 3'b000, 3'($urandom)}, 32'($urandom)});
    end
    drain(2000);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
